frame_scanner: RTL and testbench

//  Reader side of the 16x16 frame interface: accepts whole frames (initial pattern or each

---
 rtl/frame_scanner.sv | 158 +++++++++++++++
 tb/tb_frame_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanner.sv
// Double-buffered 16x16 frame scanner: takes whole frames over a valid/ready handshake
// and refreshes them onto the LED matrix one row at a time, with optional blanking.
module frame_scanner #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_en,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [15:0][15:0] frame_in,
    output logic [15:0]       row_sel,
    output logic [15:0]       col_data,
    output logic              scan_active,
    output logic              frame_done
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BLANK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0][15:0] active_q, active_d;
    logic [15:0][15:0] pending_q, pending_d;
    logic              pending_full_q, pending_full_d;
    logic              load_ready_q, load_ready_d;
    logic [15:0]       row_sel_q, row_sel_d;
    logic [15:0]       col_data_q, col_data_d;
    logic              scan_active_q, scan_active_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;
    logic              row_end;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        cnt_d          = cnt_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        row_end        = 1'b0;
        accept         = load_valid & load_ready_q;

        if (accept) begin
            pending_d      = frame_in;
            pending_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // An idle scanner bypasses the pending buffer and shows the new frame at once
                if (accept) begin
                    active_d       = frame_in;
                    pending_full_d = 1'b0;
                    state_d        = S_SCAN;
                    row_d          = '0;
                    cnt_d          = '0;
                end else if (pending_full_q && scan_en) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                    state_d        = S_SCAN;
                    row_d          = '0;
                    cnt_d          = '0;
                end
            end
            S_SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    if (BLANK == 0) begin
                        row_end = 1'b1;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    row_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (row_end) begin
            cnt_d = '0;
            if (row_q != 4'd15) begin
                state_d = S_SCAN;
                row_d   = row_q + 4'd1;
            end else begin
                // Frame boundary: swap uses the pending contents from before this edge
                row_d = '0;
                if (pending_full_q) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                end
                state_d = scan_en ? S_SCAN : S_IDLE;
            end
        end

        load_ready_d = ~pending_full_d;
        row_sel_d    = '0;
        col_data_d   = '0;
        if (state_d == S_SCAN) begin
            row_sel_d  = 16'h0001 << row_d;
            col_data_d = active_d[row_d];
        end
        scan_active_d = (state_d != S_IDLE);
        if (BLANK == 0) begin
            frame_done_d = (state_d == S_SCAN) && (row_d == 4'd15) && (cnt_d == DWELL_LAST);
        end else begin
            frame_done_d = (state_d == S_BLANK) && (row_d == 4'd15) && (cnt_d == BLANK_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            row_q          <= '0;
            cnt_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            load_ready_q   <= 1'b1;
            row_sel_q      <= '0;
            col_data_q     <= '0;
            scan_active_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            load_ready_q   <= load_ready_d;
            row_sel_q      <= row_sel_d;
            col_data_q     <= col_data_d;
            scan_active_q  <= scan_active_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign scan_active = scan_active_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner (DWELL=4, BLANK=2): a frame-phase model checked every cycle,
// plus directed literal expectations for handshake, boundary and reset behaviour.
module tb_frame_scanner;
    localparam int D      = 4;
    localparam int B      = 2;
    localparam int RP     = D + B;
    localparam int PERIOD = 16 * RP;

    typedef logic [15:0][15:0] frame_t;

    logic        clk;
    logic        reset_n;
    logic        scan_en;
    logic        load_valid;
    logic        load_ready;
    frame_t      frame_in;
    logic [15:0] row_sel;
    logic [15:0] col_data;
    logic        scan_active;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    frame_t m_act = '0;
    frame_t m_pend = '0;
    bit     m_pfull = 1'b0;
    bit     m_run = 1'b0;
    int     m_phase = 0;
    bit     m_acc;
    bit     m_bnd;

    int          e_row;
    int          e_off;
    logic [15:0] e_sel;
    logic [15:0] e_col;

    frame_t fa;
    frame_t fb;
    frame_t fones;
    int     done_cnt;

    frame_scanner #(.DWELL(D), .BLANK(B)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scan_en     (scan_en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .frame_in    (frame_in),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .scan_active (scan_active),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic en, input frame_t f);
        load_valid = valid;
        scan_en    = en;
        frame_in   = f;
        @(negedge clk);
    endtask

    // Model: a running frame is just a phase 0..PERIOD-1; row and dwell/blank follow by division
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act   <= '0;
            m_pend  <= '0;
            m_pfull <= 1'b0;
            m_run   <= 1'b0;
            m_phase <= 0;
        end else begin
            m_acc = load_valid && !m_pfull;
            m_bnd = m_run && (m_phase == PERIOD - 1);
            if (!m_run) begin
                if (m_acc) begin
                    m_act   <= frame_in;
                    m_run   <= 1'b1;
                    m_phase <= 0;
                end else if (m_pfull && scan_en) begin
                    m_act   <= m_pend;
                    m_pfull <= 1'b0;
                    m_run   <= 1'b1;
                    m_phase <= 0;
                end
            end else begin
                if (m_bnd && m_pfull) begin
                    m_act   <= m_pend;
                    m_pfull <= 1'b0;
                end
                if (m_acc) begin
                    m_pend  <= frame_in;
                    m_pfull <= 1'b1;
                end
                if (m_bnd) begin
                    m_phase <= 0;
                    m_run   <= scan_en;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            e_row = m_phase / RP;
            e_off = m_phase % RP;
            e_sel = '0;
            e_col = '0;
            if (m_run && e_off < D) begin
                e_sel = 16'h0001 << e_row;
                e_col = m_act[e_row];
            end
            checkOutput("model row_sel", row_sel, e_sel);
            checkOutput("model col_data", col_data, e_col);
            checkOutput("model scan_active", 16'(scan_active), 16'(m_run));
            checkOutput("model frame_done", 16'(frame_done), 16'(m_run && m_phase == PERIOD - 1));
            checkOutput("model load_ready", 16'(load_ready), 16'(!m_pfull));
        end
    end

    initial begin
        for (int r = 0; r < 16; r++) begin
            fa[r]    = 16'h0101 << (r % 8);
            fb[r]    = 16'h8001;
            fones[r] = 16'hFFFF;
        end
        reset_n    = 1'b0;
        scan_en    = 1'b0;
        load_valid = 1'b0;
        frame_in   = '0;

        @(negedge clk);
        checkOutput("reset row_sel", row_sel, 16'h0000);
        checkOutput("reset col_data", col_data, 16'h0000);
        checkOutput("reset load_ready", 16'(load_ready), 16'd1);
        checkOutput("reset scan_active", 16'(scan_active), 16'd0);
        checkOutput("reset frame_done", 16'(frame_done), 16'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        // First frame from IDLE appears one cycle after acceptance
        applyStimulus(1'b1, 1'b1, fa);
        checkOutput("first row_sel", row_sel, 16'h0001);
        checkOutput("first col_data", col_data, 16'h0101);
        checkOutput("first scan_active", 16'(scan_active), 16'd1);
        checkOutput("first load_ready", 16'(load_ready), 16'd1);
        repeat (3) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("dwell end row_sel", row_sel, 16'h0001);
        applyStimulus(1'b0, 1'b1, fa);
        checkOutput("blank row_sel", row_sel, 16'h0000);
        checkOutput("blank col_data", col_data, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("row1 row_sel", row_sel, 16'h0002);
        checkOutput("row1 col_data", col_data, 16'h0202);

        done_cnt = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            applyStimulus(1'b0, 1'b1, fa);
            if (frame_done) done_cnt++;
        end
        checkOutput("frame_done pulses in two frames", 16'(done_cnt), 16'd2);

        // Mid-frame load is held in pending until the boundary
        applyStimulus(1'b1, 1'b1, fones);
        checkOutput("midload load_ready", 16'(load_ready), 16'd0);
        repeat (5) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("midload old row2", col_data, 16'h0404);
        repeat (83) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("midload boundary frame_done", 16'(frame_done), 16'd1);
        applyStimulus(1'b0, 1'b1, fa);
        checkOutput("swap row_sel", row_sel, 16'h0001);
        checkOutput("swap col_data", col_data, 16'hFFFF);
        checkOutput("swap load_ready", 16'(load_ready), 16'd1);

        // Load on the boundary cycle lands one frame later; second load held off
        repeat (95) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("bnd frame_done", 16'(frame_done), 16'd1);
        applyStimulus(1'b1, 1'b1, fa);
        checkOutput("bnd load_ready", 16'(load_ready), 16'd0);
        checkOutput("bnd still old", col_data, 16'hFFFF);
        repeat (10) applyStimulus(1'b1, 1'b1, fb);
        checkOutput("held-off load_ready", 16'(load_ready), 16'd0);
        repeat (86) applyStimulus(1'b0, 1'b1, fb);
        checkOutput("late swap col_data", col_data, 16'h0101);
        checkOutput("late swap load_ready", 16'(load_ready), 16'd1);
        repeat (6) applyStimulus(1'b0, 1'b1, fb);
        checkOutput("late swap row1", col_data, 16'h0202);
        repeat (90) applyStimulus(1'b0, 1'b1, fb);
        checkOutput("held-off never shown", col_data, 16'h0101);

        // scan_en dropped at row 5 is honoured only at the boundary
        repeat (30) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("row5 row_sel", row_sel, 16'h0020);
        repeat (65) applyStimulus(1'b0, 1'b0, fa);
        checkOutput("stop frame_done", 16'(frame_done), 16'd1);
        applyStimulus(1'b0, 1'b0, fa);
        checkOutput("idle row_sel", row_sel, 16'h0000);
        checkOutput("idle scan_active", 16'(scan_active), 16'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, fa);
        checkOutput("still idle", 16'(scan_active), 16'd0);

        // Asynchronous reset while scanning
        applyStimulus(1'b1, 1'b1, fa);
        checkOutput("restart row_sel", row_sel, 16'h0001);
        repeat (7) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("pre-reset row_sel", row_sel, 16'h0002);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset row_sel", row_sel, 16'h0000);
        checkOutput("async reset col_data", col_data, 16'h0000);
        checkOutput("async reset scan_active", 16'(scan_active), 16'd0);
        checkOutput("async reset frame_done", 16'(frame_done), 16'd0);
        checkOutput("async reset load_ready", 16'(load_ready), 16'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        repeat (2) applyStimulus(1'b0, 1'b1, fa);
        checkOutput("post-reset idle", 16'(scan_active), 16'd0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
